// File: rtl/movegen_sequencer_if.sv
// Move stream from the generation sequencer to the search/move-list logic.
// A word transfers on any cycle where mv_valid and mv_ready are both high.
interface movegen_sequencer_if;
  logic [31:0] mv_data;
  logic        mv_valid;
  logic        mv_ready;

  modport master (output mv_data, output mv_valid, input mv_ready);
  modport slave  (input mv_data, input mv_valid, output mv_ready);
endinterface

// File: rtl/movegen_sequencer.sv
// Board-level move generation sequencer.
// After a start, it waits for the ray/knight chains to settle. It then walks
// squares 0..63 through the board read mux and streams every non-empty
// direction word of each square out over the move handshake.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// SETTLE | settle down-counter running after start
// ADDR   | sq_addr held while the read mux latency elapses
// LOAD   | capture the addressed square's 16 move words
// SCAN   | examine one buffered word per cycle
// EMIT   | hold mv_data/mv_valid until the consumer accepts
// DONE   | one-cycle done pulse, then back to IDLE
module movegen_sequencer #(
  parameter int SETTLE_CYCLES = 8,
  parameter int RD_LAT        = 1,
  parameter int MAX_MOVES     = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [5:0]                 sq_addr,
  input  logic [511:0]               sq_moves,
  movegen_sequencer_if.master        mv,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 move_count,
  output logic                       overflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_SCAN   = 3'd4;
  localparam logic [2:0] S_EMIT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // With zero read latency the mux output is already valid in the cycle the
  // new address appears, so ADDR is bypassed and LOAD follows directly.
  localparam logic [2:0] S_FETCH = (RD_LAT == 0) ? S_LOAD : S_ADDR;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]    LAT_INIT    = 2'(RD_LAT - 1);
  localparam logic [7:0]    MAX_CNT     = 8'(MAX_MOVES);

  logic [2:0]    state;
  logic [SW-1:0] settle_cnt;
  logic [1:0]    lat_cnt;
  logic [3:0]    slot;
  logic [511:0]  move_buf;
  logic [31:0]   word;
  logic          word_nz;
  logic          room;
  logic          step;

  // Current buffered word and slot-advance decision.
  always_comb begin
    word    = move_buf[{slot, 5'b0} +: 32];
    word_nz = (word != 32'h0);
    room    = (move_count < MAX_CNT);
    step    = 1'b0;
    if (state == S_SCAN)
      step = !(word_nz && room);
    else if (state == S_EMIT)
      step = mv.mv_ready;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Sequencer state, counters, square buffer and move stream registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      lat_cnt     <= '0;
      slot        <= '0;
      move_buf    <= '0;
      sq_addr     <= '0;
      mv.mv_data  <= '0;
      mv.mv_valid <= 1'b0;
      move_count  <= '0;
      overflow    <= 1'b0;
    end else if (abort) begin
      // Abort wins over a same-cycle acceptance: the word is not counted.
      state       <= S_IDLE;
      mv.mv_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            move_count <= '0;
            overflow   <= 1'b0;
            settle_cnt <= SETTLE_INIT;
            sq_addr    <= '0;
            lat_cnt    <= LAT_INIT;
            state      <= (SETTLE_CYCLES == 0) ? S_FETCH : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            sq_addr <= '0;
            lat_cnt <= LAT_INIT;
            state   <= S_FETCH;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_ADDR: begin
          if (lat_cnt == '0)
            state <= S_LOAD;
          else
            lat_cnt <= lat_cnt - 1'b1;
        end
        S_LOAD: begin
          move_buf <= sq_moves;
          slot     <= '0;
          state    <= S_SCAN;
        end
        S_SCAN: begin
          if (word_nz && room) begin
            mv.mv_data  <= word;
            mv.mv_valid <= 1'b1;
            state       <= S_EMIT;
          end else if (word_nz) begin
            overflow <= 1'b1;
          end
        end
        S_EMIT: begin
          if (mv.mv_ready) begin
            move_count  <= move_count + 8'd1;
            mv.mv_valid <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Slot advance is shared by a skipped/dropped word and an accepted move.
      if (step) begin
        if (slot != 4'hf) begin
          slot  <= slot + 4'd1;
          state <= S_SCAN;
        end else if (sq_addr == 6'd63) begin
          state <= S_DONE;
        end else begin
          sq_addr <= sq_addr + 6'd1;
          lat_cnt <= LAT_INIT;
          state   <= S_FETCH;
        end
      end
    end
  end

endmodule
